// File: rtl/pc_replay_pkg.sv
// Shared constants and types for the PC replay controller.
// Stage numbers name the pipeline slot whose valid bit gates each request.
package pc_replay_pkg;

  localparam int STG_JMP = 1;  // jumps are decoded in stage 1
  localparam int STG_BR  = 2;  // branches resolve in stage 2
  localparam int STG_WB  = 3;  // register writes and stores come from stage 3

  // Action applied to the fetch PC in a given cycle, lowest to highest priority.
  typedef enum logic [1:0] {
    ACT_SEQ    = 2'd0,
    ACT_JMP    = 2'd1,
    ACT_BR     = 2'd2,
    ACT_REPLAY = 2'd3
  } act_e;

endpackage

// File: rtl/pc_replay_ctrl_if.sv
// Request/status bundle between the pipeline and the PC replay controller.
// All requests are level signals sampled on the rising clock edge when stall
// is low; while stall is high the controller ignores them, so the requester
// keeps them asserted until a non-stalled edge consumes them.
interface pc_replay_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int RA_W  = 5
);
  logic                    stall;
  logic                    br_taken;
  logic [XLEN-1:0]         br_target;
  logic                    jmp;
  logic [XLEN-1:0]         jmp_target;
  logic                    wb_we;
  logic [RA_W-1:0]         wb_dst;
  logic [RA_W-1:0]         src_a1;
  logic [RA_W-1:0]         src_b1;
  logic [RA_W-1:0]         src_a2;
  logic [RA_W-1:0]         src_b2;
  logic                    st_we;
  logic [XLEN-1:0]         st_addr;
  logic [XLEN-1:0]         pc;
  logic [DEPTH*XLEN-1:0]   pc_hist;
  logic [DEPTH-1:0]        valid;
  logic                    flush;

  // Pipeline side: drives requests, observes PC state.
  modport master (
    output stall, br_taken, br_target, jmp, jmp_target, wb_we, wb_dst,
           src_a1, src_b1, src_a2, src_b2, st_we, st_addr,
    input  pc, pc_hist, valid, flush
  );

  // Controller side.
  modport slave (
    input  stall, br_taken, br_target, jmp, jmp_target, wb_we, wb_dst,
           src_a1, src_b1, src_a2, src_b2, st_we, st_addr,
    output pc, pc_hist, valid, flush
  );
endinterface

// File: rtl/pc_replay_ctrl_replay_detect.sv
// Combinational hazard detector: decides whether an older pipeline stage
// must be re-fetched because of a pending register write or store from the
// write-back stage, and from which stage (1 or 2; the older one wins).
module replay_detect
  import pc_replay_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic              i_wb_we,
  input  logic [RA_W-1:0]   i_wb_dst,
  input  logic [RA_W-1:0]   i_src_a1,
  input  logic [RA_W-1:0]   i_src_b1,
  input  logic [RA_W-1:0]   i_src_a2,
  input  logic [RA_W-1:0]   i_src_b2,
  input  logic              i_st_we,
  input  logic [XLEN-1:0]   i_st_addr,
  input  logic [XLEN-1:0]   i_hist1,
  input  logic [XLEN-1:0]   i_hist2,
  input  logic [STG_WB:1]   i_valid,
  output logic              o_replay,
  output logic [1:0]        o_stg
);
  logic w_reg_ok, w_reg1, w_reg2;
  logic w_st_ok, w_st1, w_st2;

  // Register 0 is hard-wired, so a write to it can never be a hazard.
  assign w_reg_ok = i_wb_we & i_valid[STG_WB] & (i_wb_dst != '0);
  assign w_reg2   = w_reg_ok & i_valid[2] & ((i_src_a2 == i_wb_dst) | (i_src_b2 == i_wb_dst));
  assign w_reg1   = w_reg_ok & i_valid[1] & ((i_src_a1 == i_wb_dst) | (i_src_b1 == i_wb_dst));

  assign w_st_ok  = i_st_we & i_valid[STG_WB];
  assign w_st2    = w_st_ok & i_valid[2] & (i_st_addr == i_hist2);
  assign w_st1    = w_st_ok & i_valid[1] & (i_st_addr == i_hist1);

  // Older stage has precedence: replaying it also re-fetches the younger one.
  always_comb begin
    o_replay = w_reg2 | w_reg1 | w_st2 | w_st1;
    o_stg    = 2'd0;
    if (w_reg2 | w_st2)      o_stg = 2'd2;
    else if (w_reg1 | w_st1) o_stg = 2'd1;
  end
endmodule

// File: rtl/pc_replay_ctrl.sv
// PC history / replay controller. Tracks the PC and valid bit of each
// pipeline stage, steers the fetch PC on replay, branch or jump (in that
// priority) and squashes the stages younger than the redirect point.
// Optional statistics counters are enabled with `define PC_REPLAY_STAT_EN.
module pc_replay_ctrl
  import pc_replay_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              RA_W     = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_replay_ctrl_if.slave      bus
`ifdef PC_REPLAY_STAT_EN
  ,
  output logic [31:0]          cnt_redirect,
  output logic [31:0]          cnt_replay
`endif
);
  logic [XLEN-1:0]  r_hist [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic             r_flush;

  logic             w_replay;
  logic [1:0]       w_replay_stg;
  act_e             w_act;
  logic [XLEN-1:0]  w_target;
  logic [DEPTH-1:0] w_kill;
  logic [DEPTH-1:0] w_valid_nxt;

  replay_detect #(.XLEN(XLEN), .RA_W(RA_W)) u_replay_detect (
    .i_wb_we   (bus.wb_we),
    .i_wb_dst  (bus.wb_dst),
    .i_src_a1  (bus.src_a1),
    .i_src_b1  (bus.src_b1),
    .i_src_a2  (bus.src_a2),
    .i_src_b2  (bus.src_b2),
    .i_st_we   (bus.st_we),
    .i_st_addr (bus.st_addr),
    .i_hist1   (r_hist[1]),
    .i_hist2   (r_hist[2]),
    .i_valid   (r_valid[STG_WB:1]),
    .o_replay  (w_replay),
    .o_stg     (w_replay_stg)
  );

  // Pick the single action for this cycle and the stages it squashes.
  // w_kill marks the new valid slots that would hold squashed instructions.
  always_comb begin
    w_act    = ACT_SEQ;
    w_target = r_hist[0] + XLEN'(4);
    w_kill   = '0;
    if (w_replay) begin
      w_act    = ACT_REPLAY;
      w_target = (w_replay_stg == 2'd2) ? r_hist[2] : r_hist[1];
      w_kill[1] = 1'b1;
      w_kill[2] = 1'b1;
      w_kill[3] = (w_replay_stg == 2'd2);
    end else if (bus.br_taken && r_valid[STG_BR]) begin
      w_act    = ACT_BR;
      w_target = bus.br_target;
      w_kill[1] = 1'b1;
      w_kill[2] = 1'b1;
    end else if (bus.jmp && r_valid[STG_JMP]) begin
      w_act    = ACT_JMP;
      w_target = bus.jmp_target;
      w_kill[1] = 1'b1;
    end
    w_valid_nxt = {r_valid[DEPTH-2:0], 1'b1} & ~w_kill;
  end

  // Shift history and valid bits down the pipe unless stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist[0] <= RESET_PC;
      for (int k = 1; k < DEPTH; k++) r_hist[k] <= '0;
      r_valid <= '0;
      r_flush <= 1'b0;
    end else if (bus.stall) begin
      r_flush <= 1'b0;
    end else begin
      r_hist[0] <= w_target;
      for (int k = 1; k < DEPTH; k++) r_hist[k] <= r_hist[k-1];
      r_valid <= w_valid_nxt;
      r_flush <= (w_act != ACT_SEQ);
    end
  end

  assign bus.pc    = r_hist[0];
  assign bus.valid = r_valid;
  assign bus.flush = r_flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_hist
    assign bus.pc_hist[g*XLEN +: XLEN] = r_hist[g];
  end

`ifdef PC_REPLAY_STAT_EN
  logic [31:0] r_cnt_redirect;
  logic [31:0] r_cnt_replay;

  // Count applied redirects (any non-sequential action) and replays.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_redirect <= '0;
      r_cnt_replay   <= '0;
    end else if (!bus.stall) begin
      if (w_act != ACT_SEQ)    r_cnt_redirect <= r_cnt_redirect + 32'd1;
      if (w_act == ACT_REPLAY) r_cnt_replay   <= r_cnt_replay + 32'd1;
    end
  end

  assign cnt_redirect = r_cnt_redirect;
  assign cnt_replay   = r_cnt_replay;
`endif
endmodule

// File: tb/tb_pc_replay_ctrl.sv
// Bench for pc_replay_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a stage-list reference model.
module tb_pc_replay_ctrl;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int RA_W  = 5;
  localparam int HW    = DEPTH * XLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_replay_ctrl_if #(.XLEN(XLEN), .DEPTH(DEPTH), .RA_W(RA_W)) bus ();

`ifdef PC_REPLAY_STAT_EN
  logic [31:0] cnt_redirect;
  logic [31:0] cnt_replay;
`endif

  pc_replay_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .RA_W(RA_W), .RESET_PC('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PC_REPLAY_STAT_EN
    ,
    .cnt_redirect (cnt_redirect),
    .cnt_replay   (cnt_replay)
`endif
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [XLEN-1:0]  m_hist [DEPTH];
  logic [DEPTH-1:0] m_valid;
  logic             m_flush;
  logic [31:0]      m_cnt_rd;
  logic [31:0]      m_cnt_rp;
  logic [XLEN-1:0]  exp_q [$];

  task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hist[0] = '0;
    for (int k = 1; k < DEPTH; k++) m_hist[k] = '0;
    m_valid  = '0;
    m_flush  = 1'b0;
    m_cnt_rd = '0;
    m_cnt_rp = '0;
    exp_q.delete();
  endfunction

  // One clock edge of the pipeline as described by the rules: pick the
  // highest-priority action, move every stage one slot older, insert the new
  // fetch, and mark the squashed slots invalid.
  function automatic void model_step();
    int rs;
    int s;
    logic [XLEN-1:0] t;
    if (bus.stall) begin
      m_flush = 1'b0;
    end else begin
      rs = 0;
      if (bus.wb_we && m_valid[3] && bus.wb_dst != '0) begin
        if (m_valid[2] && (bus.src_a2 == bus.wb_dst || bus.src_b2 == bus.wb_dst)) rs = 2;
        else if (m_valid[1] && (bus.src_a1 == bus.wb_dst || bus.src_b1 == bus.wb_dst)) rs = 1;
      end
      if (bus.st_we && m_valid[3]) begin
        if (m_valid[2] && bus.st_addr == m_hist[2]) rs = 2;
        else if (m_valid[1] && bus.st_addr == m_hist[1] && rs < 1) rs = 1;
      end
      s = -1;
      t = m_hist[0] + 4;
      if (rs > 0) begin
        s = rs; t = m_hist[rs]; m_cnt_rp++;
      end else if (bus.br_taken && m_valid[2]) begin
        s = 1; t = bus.br_target;
      end else if (bus.jmp && m_valid[1]) begin
        s = 0; t = bus.jmp_target;
      end
      for (int k = DEPTH - 1; k > 0; k--) begin
        m_hist[k]  = m_hist[k-1];
        m_valid[k] = m_valid[k-1];
      end
      m_hist[0]  = t;
      m_valid[0] = 1'b1;
      for (int k = 1; k <= s + 1; k++) m_valid[k] = 1'b0;
      if (s >= 0) m_cnt_rd++;
      m_flush = (s >= 0);
    end
    exp_q.push_back(m_hist[0]);
  endfunction

  task automatic compare_all();
    logic [HW-1:0]   eh;
    logic [XLEN-1:0] epc;
    for (int k = 0; k < DEPTH; k++) eh[k*XLEN +: XLEN] = m_hist[k];
    epc = exp_q.pop_front();
    check("pc", bus.pc, epc);
    check("pc_hist", bus.pc_hist, eh);
    check("valid", bus.valid, m_valid);
    check("flush", bus.flush, m_flush);
`ifdef PC_REPLAY_STAT_EN
    check("cnt_redirect", cnt_redirect, m_cnt_rd);
    check("cnt_replay", cnt_replay, m_cnt_rp);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.stall = 0; bus.br_taken = 0; bus.br_target = '0;
    bus.jmp = 0; bus.jmp_target = '0;
    bus.wb_we = 0; bus.wb_dst = '0;
    bus.src_a1 = '0; bus.src_b1 = '0; bus.src_a2 = '0; bus.src_b2 = '0;
    bus.st_we = 0; bus.st_addr = '0;
  endtask

  // Inputs change at the falling edge; DUT and model both see them at the
  // next rising edge; outputs are compared at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic rand_drive();
    bus.stall      = ($urandom_range(0, 9) == 0);
    bus.br_taken   = ($urandom_range(0, 4) == 0);
    bus.br_target  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom();
    bus.jmp        = ($urandom_range(0, 3) == 0);
    bus.jmp_target = $urandom();
    bus.wb_we      = ($urandom_range(0, 2) == 0);
    bus.wb_dst     = RA_W'($urandom_range(0, 3));
    bus.src_a1     = RA_W'($urandom_range(0, 3));
    bus.src_b1     = RA_W'($urandom_range(0, 3));
    bus.src_a2     = RA_W'($urandom_range(0, 3));
    bus.src_b2     = RA_W'($urandom_range(0, 3));
    bus.st_we      = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 2))
      0:       bus.st_addr = m_hist[1];
      1:       bus.st_addr = m_hist[2];
      default: bus.st_addr = $urandom();
    endcase
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, bus.pc, '0);
    check({tag, "_hist"}, bus.pc_hist, '0);
    check({tag, "_valid"}, bus.valid, '0);
    check({tag, "_flush"}, bus.flush, '0);
`ifdef PC_REPLAY_STAT_EN
    check({tag, "_cnt_rd"}, cnt_redirect, '0);
    check({tag, "_cnt_rp"}, cnt_replay, '0);
`endif
  endtask

  // Asynchronous reset between edges: state must clear without a clock.
  task automatic mid_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_reset_state("arst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b1;

    // Boot: sequential fetch fills the pipe one stage per cycle.
    tick(); check("boot_pc1", bus.pc, 32'h4); check("boot_v1", bus.valid, 4'b0001);
    tick(); check("boot_pc2", bus.pc, 32'h8); check("boot_v2", bus.valid, 4'b0011);
    tick(); check("boot_pc3", bus.pc, 32'hC); check("boot_v3", bus.valid, 4'b0111);
    tick(); check("boot_pc4", bus.pc, 32'h10); check("boot_v4", bus.valid, 4'b1111);

    // Taken branch squashes stages 0..1.
    bus.br_taken = 1; bus.br_target = 32'h100;
    tick(); idle();
    check("br_pc", bus.pc, 32'h100); check("br_valid", bus.valid, 4'b1001);
    check("br_flush", bus.flush, 1'b1);
    tick(); check("br_flush_drop", bus.flush, 1'b0); check("br_seq", bus.pc, 32'h104);
    tick(); tick();
    check("refill1_v", bus.valid, 4'b1111);

    // Register replay from stage 1 beats a simultaneous jump.
    bus.jmp = 1; bus.jmp_target = 32'h40;
    bus.wb_we = 1; bus.wb_dst = 5; bus.src_b1 = 5;
    tick(); idle();
    check("rp1_pc", bus.pc, 32'h108); check("rp1_v21", bus.valid[2:1], 2'b00);
    check("rp1_flush", bus.flush, 1'b1);
    tick(); tick(); tick();
    check("refill2_pc", bus.pc, 32'h114);

    // Store hazard on stage 2 outranks a stage-1 register hazard.
    bus.st_we = 1; bus.st_addr = m_hist[2];
    bus.wb_we = 1; bus.wb_dst = 7; bus.src_a1 = 7;
    tick(); idle();
    check("rp2_pc", bus.pc, 32'h10C); check("rp2_v31", bus.valid[3:1], 3'b000);
    tick(); tick(); tick();

    // A write to register 0 never replays.
    bus.wb_we = 1; bus.wb_dst = 0;
    tick(); idle();
    check("r0_pc", bus.pc, 32'h11C); check("r0_valid", bus.valid, 4'b1111);
    check("r0_flush", bus.flush, 1'b0);

    // Branch to top of address space, then two stalled cycles, then wrap.
    bus.br_taken = 1; bus.br_target = 32'hFFFF_FFFC;
    tick(); idle();
    check("wrapbr_pc", bus.pc, 32'hFFFF_FFFC);
    bus.stall = 1; bus.br_taken = 1; bus.br_target = 32'h200; bus.jmp = 1;
    tick(); check("stall1_pc", bus.pc, 32'hFFFF_FFFC); check("stall1_flush", bus.flush, 1'b0);
    tick(); check("stall2_pc", bus.pc, 32'hFFFF_FFFC); check("stall2_valid", bus.valid, 4'b1001);
    idle();
    tick(); check("wrap_pc", bus.pc, 32'h0);
`ifdef PC_REPLAY_STAT_EN
    check("stat_rd", cnt_redirect, 32'd4);
    check("stat_rp", cnt_replay, 32'd2);
`endif

    // Random traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        idle();
        mid_reset();
      end
      rand_drive();
      tick();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
